// File: rtl/memory_stage.sv
// Y86-64 memory stage: byte-addressed little-endian data memory with
// combinational reads, clocked 8-byte writes and a sticky processor status.
module memory_stage #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  input  logic        imem_error,
  input  logic        instr_invalid,
  output logic [63:0] valM,
  output logic        dmem_error,
  output logic [2:0]  stat
);

  localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  localparam logic [3:0] IC_HALT   = 4'h0;
  localparam logic [3:0] IC_RMMOVQ = 4'h4;
  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_CALL   = 4'h8;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_PUSHQ  = 4'hA;
  localparam logic [3:0] IC_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic {
    S_RUN     = 1'b0,
    S_STOPPED = 1'b1
  } state_t;

  logic [7:0]    r_mem [MEM_BYTES];
  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_stat;
  logic [2:0]    w_stat_nxt;

  logic          w_rd;
  logic          w_wr;
  logic [63:0]   w_addr;
  logic [63:0]   w_wdata;
  logic [AW-1:0] w_idx;
  logic [63:0]   w_rdata;
  logic          w_wr_en;

  // Access decode: which icodes touch memory, and which operand is the address
  always_comb begin
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_addr  = valE;
    w_wdata = valA;
    case (icode)
      IC_RMMOVQ: w_wr = 1'b1;
      IC_MRMOVQ: w_rd = 1'b1;
      IC_CALL: begin
        w_wr    = 1'b1;
        w_wdata = valP;
      end
      IC_RET: begin
        w_rd   = 1'b1;
        w_addr = valA;
      end
      IC_PUSHQ:  w_wr = 1'b1;
      IC_POPQ: begin
        w_rd   = 1'b1;
        w_addr = valA;
      end
      default: ;
    endcase
  end

  assign dmem_error = (w_rd | w_wr) & (w_addr > MAX_ADDR);
  assign w_idx      = w_addr[AW-1:0];

  // Little-endian gather of the 8 bytes at the access address
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      w_rdata[8*i +: 8] = r_mem[w_idx + AW'(i)];
    end
  end

  assign valM = (w_rd && !dmem_error) ? w_rdata : 64'd0;

  assign w_wr_en = rst_n & w_wr & ~dmem_error & ~imem_error & ~instr_invalid &
                   (r_stat == STAT_AOK);

  // Memory is intentionally not reset; all 8 bytes commit together or not at all
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 8; i++) begin
        r_mem[w_idx + AW'(i)] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_stat  <= STAT_AOK;
    end else begin
      r_state <= w_state_nxt;
      r_stat  <= w_stat_nxt;
    end
  end

  // Status priority while running: address fault, then illegal instr, then halt
  always_comb begin
    w_state_nxt = r_state;
    w_stat_nxt  = r_stat;
    case (r_state)
      S_RUN: begin
        if (imem_error || dmem_error) begin
          w_state_nxt = S_STOPPED;
          w_stat_nxt  = STAT_ADR;
        end else if (instr_invalid) begin
          w_state_nxt = S_STOPPED;
          w_stat_nxt  = STAT_INS;
        end else if (icode == IC_HALT) begin
          w_state_nxt = S_STOPPED;
          w_stat_nxt  = STAT_HLT;
        end else begin
          w_stat_nxt  = STAT_AOK;
        end
      end
      S_STOPPED: ;
      default: begin
        w_state_nxt = S_RUN;
        w_stat_nxt  = STAT_AOK;
      end
    endcase
  end

  assign stat = r_stat;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage: load/store, call/ret,
// bounds, status priority and reset behaviour.
module tb_memory_stage;

  logic        clk;
  logic        rst_n;
  logic [3:0]  icode;
  logic [63:0] valA;
  logic [63:0] valE;
  logic [63:0] valP;
  logic        imem_error;
  logic        instr_invalid;
  logic [63:0] valM;
  logic        dmem_error;
  logic [2:0]  stat;

  int n_checks;
  int n_errors;

  memory_stage #(.MEM_BYTES(1024)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icode         (icode),
    .valA          (valA),
    .valE          (valE),
    .valP          (valP),
    .imem_error    (imem_error),
    .instr_invalid (instr_invalid),
    .valM          (valM),
    .dmem_error    (dmem_error),
    .stat          (stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                       input logic [63:0] p);
    icode         = ic;
    valA          = a;
    valE          = e;
    valP          = p;
    imem_error    = 1'b0;
    instr_invalid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_stat_async", 64'(stat), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1;
    drive(4'h1, 64'd0, 64'd0, 64'd0);
    do_reset();
    check("stat_after_reset", 64'(stat), 64'd1);

    // Store then load, little-endian byte order
    drive(4'h4, 64'h0123_4567_89AB_CDEF, 64'd16, 64'd0);
    check("rmmovq_valm_zero", valM, 64'd0);
    check("rmmovq_no_err", 64'(dmem_error), 64'd0);
    step();
    drive(4'h5, 64'd0, 64'd16, 64'd0);
    check("mrmovq_16", valM, 64'h0123_4567_89AB_CDEF);
    check("mrmovq_byte0", 64'(valM[7:0]), 64'hEF);
    check("stat_aok", 64'(stat), 64'd1);
    drive(4'hB, 64'd16, 64'd999, 64'd0);
    check("popq_uses_valA", valM, 64'h0123_4567_89AB_CDEF);

    // Call/ret at the top legal word
    drive(4'h8, 64'd0, 64'h3F8, 64'h42);
    step();
    drive(4'h9, 64'h3F8, 64'd0, 64'd0);
    check("ret_valm", valM, 64'h42);
    check("ret_no_err", 64'(dmem_error), 64'd0);
    drive(4'h5, 64'd0, 64'd1016, 64'd0);
    check("bound_1016_ok", 64'(dmem_error), 64'd0);

    // Pushq writes valA at valE
    drive(4'hA, 64'h1122_3344_5566_7788, 64'd0, 64'd0);
    step();
    drive(4'h5, 64'd0, 64'd0, 64'd0);
    check("pushq_readback", valM, 64'h1122_3344_5566_7788);

    // Boundary and no-access cases
    drive(4'h9, 64'd1017, 64'd0, 64'd0);
    check("ret_1017_err", 64'(dmem_error), 64'd1);
    drive(4'h5, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0);
    check("wrap_err", 64'(dmem_error), 64'd1);
    check("wrap_valm_zero", valM, 64'd0);
    drive(4'h1, 64'd1017, 64'd1017, 64'd0);
    check("nop_no_err", 64'(dmem_error), 64'd0);
    check("nop_valm_zero", valM, 64'd0);
    drive(4'h5, 64'd1017, 64'd0, 64'd0);
    check("mrmovq_addr_valE", 64'(dmem_error), 64'd0);

    // Out-of-range load stops with ADR; later store is suppressed
    drive(4'h5, 64'd0, 64'd1017, 64'd0);
    check("oob_err", 64'(dmem_error), 64'd1);
    check("oob_valm_zero", valM, 64'd0);
    step();
    check("oob_stat_adr", 64'(stat), 64'd3);
    drive(4'h4, 64'd5, 64'd0, 64'd0);
    step();
    drive(4'h5, 64'd0, 64'd0, 64'd0);
    check("stopped_no_write", valM, 64'h1122_3344_5566_7788);
    check("stopped_stat_hold", 64'(stat), 64'd3);
    drive(4'h0, 64'd0, 64'd0, 64'd0);
    step();
    check("stopped_ignore_halt", 64'(stat), 64'd3);

    // Priority: all three faults at once -> ADR
    do_reset();
    drive(4'h0, 64'd0, 64'd0, 64'd0);
    imem_error    = 1'b1;
    instr_invalid = 1'b1;
    step();
    check("prio_adr", 64'(stat), 64'd3);

    do_reset();
    drive(4'h1, 64'd0, 64'd0, 64'd0);
    instr_invalid = 1'b1;
    step();
    check("prio_ins", 64'(stat), 64'd4);

    // imem_error on a store: write suppressed, ADR
    do_reset();
    drive(4'h4, 64'd99, 64'd0, 64'd0);
    imem_error = 1'b1;
    step();
    check("imem_err_stat", 64'(stat), 64'd3);
    drive(4'h5, 64'd0, 64'd0, 64'd0);
    check("imem_err_no_write", valM, 64'h1122_3344_5566_7788);

    // Halt sticks and blocks stores
    do_reset();
    drive(4'h4, 64'h5555, 64'd8, 64'd0);
    step();
    drive(4'h0, 64'd0, 64'd0, 64'd0);
    step();
    check("halt_stat", 64'(stat), 64'd2);
    drive(4'h4, 64'd77, 64'd0, 64'd0);
    step();
    step();
    check("halt_sticky", 64'(stat), 64'd2);
    drive(4'h5, 64'd0, 64'd0, 64'd0);
    check("halt_no_write", valM, 64'h1122_3344_5566_7788);

    // Asynchronous reset mid-cycle, store held across an edge in reset
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_stat", 64'(stat), 64'd1);
    drive(4'h4, 64'hAA, 64'd8, 64'd0);
    step();
    rst_n = 1'b1;
    drive(4'h5, 64'd0, 64'd8, 64'd0);
    check("rst_no_write", valM, 64'h5555);
    drive(4'h4, 64'hAA, 64'd8, 64'd0);
    step();
    check("resume_stat", 64'(stat), 64'd1);
    drive(4'h5, 64'd0, 64'd8, 64'd0);
    check("resume_write", valM, 64'hAA);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
